// File: rtl/lap_timer_pkg.sv
// rtl/lap_timer_pkg.sv - shared types and helpers for the lap timer
package lap_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_e;

    typedef enum logic {
        MODE_DOWN = 1'b0,
        MODE_UP   = 1'b1
    } mode_e;

    // Wide enough for any counter width, with one carry bit kept below.
    localparam int unsigned SAT_W = 32;

    function automatic logic [SAT_W-1:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input logic [SAT_W-1:0] ceil
    );
        logic [SAT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, ceil}) ? ceil : sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/lap_fifo.sv
// rtl/lap_fifo.sv - first-word-fall-through lap capture FIFO with drop flag
module lap_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             full,
    output logic             drop
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             drop_q, drop_d;
    logic             pop_eff;
    logic             push_eff;

    // Pointers carry a wrap bit so equal indices distinguish full from empty.
    assign valid = (wr_ptr_q != rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees a slot in the same cycle, so a push into a full FIFO succeeds.
    assign pop_eff  = pop && valid && !flush;
    assign push_eff = push && !flush && (!full || pop_eff);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        drop_d   = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_eff) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_eff)  rd_ptr_d = rd_ptr_q + 1'b1;
            drop_d = push && !push_eff;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) mem[wr_ptr_q[AW-1:0]] <= data_in;
    end

    assign head = valid ? mem[rd_ptr_q[AW-1:0]] : '0;
    assign drop = drop_q;

endmodule

// File: rtl/lap_timer.sv
// rtl/lap_timer.sv - countdown timer / count-up stopwatch with lap FIFO
module lap_timer
    import lap_timer_pkg::*;
#(
    parameter int unsigned CNT_W     = 12,
    parameter int unsigned MAX_COUNT = 4095,
    parameter int unsigned STEP      = 30,
    parameter int unsigned LAP_DEPTH = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             tick,
    input  logic             mode,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             add_step,
    input  logic             lap,
    input  logic             lap_pop,
    output logic [CNT_W-1:0] count,
    output logic             time_up,
    output logic             overflow,
    output logic [CNT_W-1:0] lap_data,
    output logic             lap_valid,
    output logic             lap_full,
    output logic             lap_drop,
    output logic             running
);

    localparam logic [SAT_W-1:0] MAX_W = SAT_W'(MAX_COUNT);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             time_up_q, time_up_d;
    logic             overflow_q, overflow_d;
    logic             fifo_push;
    logic             fifo_flush;
    logic [CNT_W-1:0] load_clamped;
    logic [CNT_W-1:0] step_sum;
    logic [CNT_W-1:0] step_sum_tick;

    assign load_clamped  = CNT_W'(sat_add(SAT_W'(load_val), '0, MAX_W));
    assign step_sum      = CNT_W'(sat_add(SAT_W'(count_q), SAT_W'(STEP), MAX_W));
    assign step_sum_tick = CNT_W'(sat_add(SAT_W'(count_q), SAT_W'(STEP - 1), MAX_W));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            mode_q     <= MODE_DOWN;
            count_q    <= '0;
            time_up_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            count_q    <= count_d;
            time_up_q  <= time_up_d;
            overflow_q <= overflow_d;
        end
    end

    // A command that changes state swallows the lower-priority commands that cycle.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        count_d    = count_q;
        time_up_d  = time_up_q;
        overflow_d = overflow_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        if (clear) begin
            state_d    = IDLE;
            count_d    = '0;
            time_up_d  = 1'b0;
            overflow_d = 1'b0;
            fifo_flush = 1'b1;
        end else if (load) begin
            state_d    = IDLE;
            count_d    = load_clamped;
            time_up_d  = 1'b0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_d = mode_e'(mode);
                        if (mode == MODE_DOWN && count_q == '0) begin
                            state_d   = EXPIRED;
                            time_up_d = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end else if (add_step && mode == MODE_DOWN) begin
                        count_d = step_sum;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (mode_q == MODE_DOWN) begin
                        if (add_step) begin
                            count_d = tick ? step_sum_tick : step_sum;
                        end else if (tick) begin
                            if (count_q <= CNT_W'(1)) begin
                                count_d   = '0;
                                time_up_d = 1'b1;
                                state_d   = EXPIRED;
                            end else begin
                                count_d = count_q - CNT_W'(1);
                            end
                        end
                    end else begin
                        fifo_push = lap;
                        if (tick) begin
                            if (count_q < CNT_W'(MAX_COUNT)) count_d = count_q + CNT_W'(1);
                            else overflow_d = 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (start) begin
                        state_d = RUN;
                    end else if (mode_q == MODE_DOWN) begin
                        if (add_step) count_d = step_sum;
                    end else begin
                        fifo_push = lap;
                    end
                end
                EXPIRED: begin
                    state_d = EXPIRED;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    lap_fifo #(
        .WIDTH (CNT_W),
        .DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .push    (fifo_push),
        .pop     (lap_pop && !clear),
        .flush   (fifo_flush),
        .data_in (count_q),
        .head    (lap_data),
        .valid   (lap_valid),
        .full    (lap_full),
        .drop    (lap_drop)
    );

    always_comb begin
        count    = count_q;
        time_up  = time_up_q;
        overflow = overflow_q;
        running  = (state_q == RUN);
    end

endmodule

// File: doc/lap_timer.md
Name: lap_timer

Overview:
Parametrised successor to the single-mode stopwatch/timer counter. Operates as a countdown timer with a step-add button, or as a count-up stopwatch with a lap-capture FIFO. Advances only on a one-cycle `tick` strobe supplied by the shared clock divider. Sits between the button debounce/edge-detect logic and the display/readout path.

Parameters:
CNT_W, 12, counter width in bits
MAX_COUNT, 4095, saturation ceiling; must be ≤ 2^CNT_W-1
STEP, 30, amount added per add_step press in DOWN mode
LAP_DEPTH, 4, lap FIFO entries; power of two, ≥2

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
tick  in  1  one-cycle count-enable strobe from clock divider
mode  in  1  0=DOWN (timer), 1=UP (stopwatch); sampled only on start from IDLE
start  in  1  begin/resume counting (pulse)
stop  in  1  pause counting (pulse)
clear  in  1  zero counter, flush laps, return to IDLE (pulse)
load  in  1  load load_val into counter (pulse)
load_val  in  CNT_W  preset value
add_step  in  1  add STEP to counter (pulse)
lap  in  1  capture current count into lap FIFO (pulse)
lap_pop  in  1  discard FIFO head
count  out  CNT_W  current counter value
time_up  out  1  DOWN-mode expiry flag, sticky
overflow  out  1  UP-mode saturation flag, sticky
lap_data  out  CNT_W  FIFO head (first-word-fall-through)
lap_valid  out  1  FIFO non-empty
lap_full  out  1  FIFO full
lap_drop  out  1  one-cycle pulse: lap discarded because FIFO was full
running  out  1  state==RUN

Behaviour:
- One clock domain, asynchronous active-low reset (nrst). Every output and register except the FIFO storage array is a flop with a defined reset value.
- Reset values:
  - count=0, time_up=0, overflow=0, lap_drop=0.
  - FIFO empty: lap_valid=0, lap_full=0, lap_data=0.
  - state=IDLE, mode_q=DOWN.
- FSM states: IDLE, RUN, PAUSE, EXPIRED. All outputs are registered; effects appear one cycle after the input pulse.
- Command priority, highest first: clear > load > start/stop > add_step/lap > tick.
- clear (any state):
  - count=0, time_up=0, overflow=0, FIFO flushed, state→IDLE.
  - Other inputs that cycle are ignored, including lap_pop.
- load (any state, no clear):
  - count=min(load_val, MAX_COUNT), time_up=0, overflow=0, state→IDLE.
  - FIFO is untouched.
- IDLE:
  - start latches mode into mode_q. If mode=DOWN and count==0, state→EXPIRED and time_up=1; otherwise state→RUN.
- RUN:
  - stop→PAUSE. If stop and start arrive together, stop wins.
  - tick in DOWN: count-1. If count==1, the same edge sets count=0, time_up=1, state→EXPIRED. No underflow ever occurs.
  - tick in UP: if count<MAX_COUNT, count+1. Otherwise count holds and overflow=1; state stays RUN.
- PAUSE:
  - start→RUN; tick is ignored.
- EXPIRED:
  - count holds at 0 and time_up holds at 1.
  - Only clear or load exits. start, stop, tick, add_step and lap are ignored.
- add_step:
  - Acts only when mode_q=DOWN (or the mode input is DOWN while in IDLE) and state≠EXPIRED.
  - count=min(count+STEP, MAX_COUNT). Sum computed in CNT_W+1 bits before the clamp.
  - If add_step and tick coincide in RUN, the result is count+STEP-1, clamped.
  - Ignored in UP mode.
- lap:
  - Acts only when mode_q=UP and state∈{RUN, PAUSE}.
  - Pushes the pre-tick count value.
  - If the FIFO is full and no pop occurs the same cycle, the entry is dropped and lap_drop pulses for one cycle.
  - lap and lap_pop together when full: both succeed and occupancy is unchanged.
- lap_pop:
  - When empty, ignored.
  - Otherwise the head advances next cycle.
  - lap_data is valid only while lap_valid=1.
- FIFO pointers carry an extra wrap bit; full/empty are derived from the pointers.

Decomposition:
- Package lap_timer_pkg holds:
  - state enum (IDLE, RUN, PAUSE, EXPIRED);
  - mode enum (MODE_DOWN=0, MODE_UP=1);
  - a saturating-add helper function.
- Sub-module lap_fifo: parametrised by width and depth. Interface: push, pop, flush, data_in; outputs head, valid, full, drop.
- lap_timer contains the FSM, counter datapath and lap_fifo instance.

Test Plan:
1. DOWN mode: load 3, start, 3 ticks → count 2,1,0; time_up=1 and state EXPIRED on the 3rd tick edge. A 4th tick leaves count=0.
2. DOWN mode: load 4080, add_step → count=4095 (clamped). Then add_step together with tick in RUN at count=10 → count=39.
3. UP mode: load 4094, start, 3 ticks → count 4095, overflow=1 after the 2nd tick; count stays 4095.
4. UP mode: laps at counts 5, 9, 12, 20, 25 with LAP_DEPTH=4 → lap_full=1 after the 4th lap; lap_drop pulses on the 5th. Pops return 5, 9, 12, 20, then lap_valid=0.
5. Priority: clear+load+start in the same cycle while RUN → count=0, IDLE, FIFO empty. stop+start in RUN → PAUSE; ticks in PAUSE leave count unchanged.
6. Assert nrst mid-RUN between clock edges → all outputs return to reset values immediately, without waiting for a clock edge. After release, start in DOWN mode with count=0 → EXPIRED, time_up=1.
